// File: rtl/topk_sorter.sv
// K-entry insertion-sorted (data, count) register array that keeps the highest counts in
// descending order, with drain FSM, clear and status outputs. Optional macro: TOPK_DEDUP_EN.
module topk_sorter #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH_SIZE = 6,
  parameter int K           = 8,
  parameter int OCC_SIZE    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_SIZE-1:0]   in_data,
  input  logic [LENGTH_SIZE-1:0] in_count,
  input  logic                   start_drain,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_SIZE-1:0]   out_data,
  output logic [LENGTH_SIZE-1:0] out_count,
  output logic                   out_last,
  output logic                   drain_done,
  output logic [OCC_SIZE-1:0]    occupancy,
  output logic [LENGTH_SIZE-1:0] min_count
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t state;

  logic                   valid_q [K];
  logic [DATA_SIZE-1:0]   data_q  [K];
  logic [LENGTH_SIZE-1:0] count_q [K];

  logic                   cv [K];
  logic [DATA_SIZE-1:0]   cd [K];
  logic [LENGTH_SIZE-1:0] cc [K];
  logic                   nv [K];
  logic [DATA_SIZE-1:0]   nd [K];
  logic [LENGTH_SIZE-1:0] nc [K];

  logic                   accept;
  logic                   found;
  logic                   fits;
  int                     p;
  logic [OCC_SIZE-1:0]    occ_n;
  logic [LENGTH_SIZE-1:0] min_n;
  logic [OCC_SIZE-1:0]    rd;
  logic                   rd_valid;
  logic                   rd_next_valid;
  logic [DATA_SIZE-1:0]   rd_data;
  logic [LENGTH_SIZE-1:0] rd_count;

`ifdef TOPK_DEDUP_EN
  logic hit;
  int   m;
`endif

  assign in_ready = (state == COLLECT);
  assign accept   = in_valid && in_ready && (in_count != '0);

  always_comb begin
    found = 1'b0;
    fits  = 1'b0;
    p     = 0;
    for (int i = 0; i < K; i++) begin
      cv[i] = valid_q[i];
      cd[i] = data_q[i];
      cc[i] = count_q[i];
    end
`ifdef TOPK_DEDUP_EN
    hit = 1'b0;
    m   = 0;
    for (int i = 0; i < K; i++) begin
      if (!hit && valid_q[i] && (data_q[i] == in_data)) begin
        hit = 1'b1;
        m   = i;
      end
      if (!valid_q[i] || (in_count > count_q[i])) fits = 1'b1;
    end
    // Remove the matching symbol first; whether it re-enters is judged against the original list.
    if (accept && hit) begin
      for (int i = 0; i < K - 1; i++) begin
        if (i >= m) begin
          cv[i] = valid_q[i+1];
          cd[i] = data_q[i+1];
          cc[i] = count_q[i+1];
        end
      end
      cv[K-1] = 1'b0;
      cd[K-1] = '0;
      cc[K-1] = '0;
    end
`endif
    for (int i = 0; i < K; i++) begin
      if (!found && (!cv[i] || (in_count > cc[i]))) begin
        found = 1'b1;
        p     = i;
      end
    end
`ifndef TOPK_DEDUP_EN
    fits = found;
`endif
    for (int i = 0; i < K; i++) begin
      nv[i] = cv[i];
      nd[i] = cd[i];
      nc[i] = cc[i];
    end
    if (accept && fits && found) begin
      for (int i = 1; i < K; i++) begin
        if (i > p) begin
          nv[i] = cv[i-1];
          nd[i] = cd[i-1];
          nc[i] = cc[i-1];
        end
      end
      for (int i = 0; i < K; i++) begin
        if (i == p) begin
          nv[i] = 1'b1;
          nd[i] = in_data;
          nc[i] = in_count;
        end
      end
    end
    occ_n = '0;
    for (int i = 0; i < K; i++) occ_n = occ_n + {{(OCC_SIZE-1){1'b0}}, nv[i]};
    min_n = nv[K-1] ? nc[K-1] : '0;
  end

  always_comb begin
    rd_valid      = 1'b0;
    rd_next_valid = 1'b0;
    rd_data       = '0;
    rd_count      = '0;
    for (int i = 0; i < K; i++) begin
      if (rd == OCC_SIZE'(i)) begin
        rd_valid = valid_q[i];
        rd_data  = data_q[i];
        rd_count = count_q[i];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      if (rd == OCC_SIZE'(i)) rd_next_valid = valid_q[i+1];
    end
  end

  assign out_valid = (state == DRAIN) && rd_valid;
  assign out_data  = rd_data;
  assign out_count = rd_count;
  assign out_last  = out_valid && ((rd == OCC_SIZE'(K - 1)) || !rd_next_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      rd         <= '0;
      drain_done <= 1'b0;
      occupancy  <= '0;
      min_count  <= '0;
      for (int i = 0; i < K; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      drain_done <= 1'b0;
      if (clear) begin
        state     <= COLLECT;
        rd        <= '0;
        occupancy <= '0;
        min_count <= '0;
        for (int i = 0; i < K; i++) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
          count_q[i] <= '0;
        end
      end else begin
        case (state)
          COLLECT: begin
            for (int i = 0; i < K; i++) begin
              valid_q[i] <= nv[i];
              data_q[i]  <= nd[i];
              count_q[i] <= nc[i];
            end
            occupancy <= occ_n;
            min_count <= min_n;
            if (start_drain) begin
              state <= DRAIN;
              rd    <= '0;
            end
          end
          DRAIN: begin
            // An empty slot at the read index only happens when the list was empty on entry.
            if (!rd_valid || (out_ready && out_last)) begin
              state      <= COLLECT;
              rd         <= '0;
              drain_done <= 1'b1;
              occupancy  <= '0;
              min_count  <= '0;
              for (int i = 0; i < K; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                count_q[i] <= '0;
              end
            end else if (out_ready) begin
              rd <= rd + 1'b1;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule
